// File: rtl/forex_update_ingress.sv
// forex_update_ingress
// Host-side ingress stage for the FOREX arbitrage peripheral. Byte-wide
// Avalon-MM writes stage one edge update (source, destination, 32-bit
// log-weight); a commit write pushes the staged record into a small FIFO
// that drains to the graph container over a valid/ready handshake.
//
// Ports
//   clk         system clock, all state on rising edge
//   reset       synchronous active-low reset
//   writedata   Avalon write data (8 bits)
//   write       Avalon write strobe
//   chipselect  Avalon chip select
//   address     Avalon register address (3 bits)
//   upd_valid   FIFO head holds a valid update
//   upd_ready   container accepts head this cycle
//   upd_src     head source index
//   upd_dst     head destination index
//   upd_weight  head weight
//   fifo_full   FIFO holds DEPTH entries
//   drop_count  commits rejected while full, saturating at 255
module forex_update_ingress #(
  parameter int DEPTH    = 4,
  parameter int NODE_W   = 5,
  parameter int WEIGHT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          writedata,
  input  logic                write,
  input  logic                chipselect,
  input  logic [2:0]          address,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [NODE_W-1:0]   upd_src,
  output logic [NODE_W-1:0]   upd_dst,
  output logic [WEIGHT_W-1:0] upd_weight,
  output logic                fifo_full,
  output logic [7:0]          drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 2 * NODE_W + WEIGHT_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NODE_W-1:0]   stage_src_q, stage_src_d;
  logic [NODE_W-1:0]   stage_dst_q, stage_dst_d;
  logic [WEIGHT_W-1:0] stage_weight_q, stage_weight_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          drop_q, drop_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic wr_en, commit, flush, full, push, pop;
  logic [ENT_W-1:0] head;

  assign wr_en  = chipselect && write;
  assign commit = wr_en && (address == 3'd6);
  assign flush  = wr_en && (address == 3'd7) && writedata[0];
  // Full comes from the registered count only, so a commit that coincides
  // with a pop from a full FIFO is still rejected.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign push   = commit && !full;
  assign pop    = (count_q != '0) && upd_ready;

  always_comb begin
    stage_src_d    = stage_src_q;
    stage_dst_d    = stage_dst_q;
    stage_weight_d = stage_weight_q;
    if (wr_en) begin
      case (address)
        3'd0: stage_src_d           = writedata[NODE_W-1:0];
        3'd1: stage_dst_d           = writedata[NODE_W-1:0];
        3'd2: stage_weight_d[7:0]   = writedata;
        3'd3: stage_weight_d[15:8]  = writedata;
        3'd4: stage_weight_d[23:16] = writedata;
        3'd5: stage_weight_d[31:24] = writedata;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush) begin
      // Flush wins over any same-cycle pop; commit cannot coincide.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (commit && full) drop_d = sat_inc8(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_src_q    <= '0;
      stage_dst_q    <= '0;
      stage_weight_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      drop_q         <= '0;
    end else begin
      stage_src_q    <= stage_src_d;
      stage_dst_q    <= stage_dst_d;
      stage_weight_q <= stage_weight_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      drop_q         <= drop_d;
    end
  end

  // Entry storage carries no reset; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {stage_src_q, stage_dst_q, stage_weight_q};
  end

  // Head fields are forced to zero while empty so outputs read 0 after reset.
  assign head       = upd_valid ? mem_q[rd_ptr_q] : '0;
  assign upd_valid  = (count_q != '0);
  assign upd_src    = head[ENT_W-1 -: NODE_W];
  assign upd_dst    = head[WEIGHT_W +: NODE_W];
  assign upd_weight = head[WEIGHT_W-1:0];
  assign fifo_full  = full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_forex_update_ingress.sv
module tb_forex_update_ingress;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  writedata = '0;
  logic        write = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = '0;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [4:0]  upd_src;
  logic [4:0]  upd_dst;
  logic [31:0] upd_weight;
  logic        fifo_full;
  logic [7:0]  drop_count;

  int vectors = 0;
  int miscompares = 0;

  forex_update_ingress #(.DEPTH(4), .NODE_W(5), .WEIGHT_W(32)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_src(upd_src), .upd_dst(upd_dst),
    .upd_weight(upd_weight), .fifo_full(fifo_full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cs, input logic we, input logic [2:0] a, input logic [7:0] d);
    chipselect = cs;
    write      = we;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus(1'b1, 1'b1, a, d);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check("rst_valid", 32'(upd_valid), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_src", 32'(upd_src), 32'd0);
    check("rst_dst", 32'(upd_dst), 32'd0);
    check("rst_weight", upd_weight, 32'd0);

    // single record passes straight through
    upd_ready = 1'b1;
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd7);
    wr(3'd2, 8'h78);
    wr(3'd3, 8'h56);
    wr(3'd4, 8'h34);
    wr(3'd5, 8'h12);
    check("t1_idle", 32'(upd_valid), 32'd0);
    wr(3'd6, 8'h00);
    check("t1_valid", 32'(upd_valid), 32'd1);
    check("t1_src", 32'(upd_src), 32'd3);
    check("t1_dst", 32'(upd_dst), 32'd7);
    check("t1_weight", upd_weight, 32'h12345678);
    tick();
    check("t1_drained", 32'(upd_valid), 32'd0);

    // fill with ready low, fifth commit dropped, then drain in order
    upd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr(3'd0, 8'(i));
      wr(3'd6, 8'h00);
      if (i == 3) check("t2_notfull3", 32'(fifo_full), 32'd0);
      if (i == 4) check("t2_full4", 32'(fifo_full), 32'd1);
    end
    check("t2_full5", 32'(fifo_full), 32'd1);
    check("t2_drop", 32'(drop_count), 32'd1);
    upd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t2_valid", 32'(upd_valid), 32'd1);
      check("t2_src", 32'(upd_src), 32'(k));
      check("t2_dst", 32'(upd_dst), 32'd7);
      tick();
    end
    check("t2_empty", 32'(upd_valid), 32'd0);
    check("t2_notfull", 32'(fifo_full), 32'd0);

    // commit coinciding with a pop from a full FIFO is dropped
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(3'd6, 8'h00);
    check("t3_full", 32'(fifo_full), 32'd1);
    upd_ready = 1'b1;
    wr(3'd6, 8'h00);
    check("t3_drop", 32'(drop_count), 32'd2);
    check("t3_notfull", 32'(fifo_full), 32'd0);
    tick(); tick();
    check("t3_one_left", 32'(upd_valid), 32'd1);
    tick();
    check("t3_empty", 32'(upd_valid), 32'd0);

    // drop counter saturation, no-op control write, flush
    upd_ready = 1'b0;
    wr(3'd0, 8'd11);
    wr(3'd1, 8'd22);
    for (int i = 0; i < 4; i++) wr(3'd6, 8'h00);
    for (int i = 0; i < 300; i++) wr(3'd6, 8'h00);
    check("t4_sat", 32'(drop_count), 32'd255);
    wr(3'd7, 8'hFE);
    check("t4_noop_drop", 32'(drop_count), 32'd255);
    check("t4_noop_valid", 32'(upd_valid), 32'd1);
    upd_ready = 1'b1;
    wr(3'd7, 8'h01);
    check("t4_flush_valid", 32'(upd_valid), 32'd0);
    check("t4_flush_drop", 32'(drop_count), 32'd0);
    check("t4_flush_full", 32'(fifo_full), 32'd0);
    upd_ready = 1'b0;
    wr(3'd6, 8'h00);
    check("t4_re_valid", 32'(upd_valid), 32'd1);
    check("t4_re_src", 32'(upd_src), 32'd11);
    check("t4_re_dst", 32'(upd_dst), 32'd22);
    check("t4_re_weight", upd_weight, 32'h12345678);
    upd_ready = 1'b1;
    tick();
    check("t4_re_empty", 32'(upd_valid), 32'd0);

    // reset mid-operation discards queued entries and staging
    upd_ready = 1'b0;
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h00);
    check("t5_queued", 32'(upd_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_valid", 32'(upd_valid), 32'd0);
    check("t5_src", 32'(upd_src), 32'd0);
    check("t5_weight", upd_weight, 32'd0);
    check("t5_drop", 32'(drop_count), 32'd0);
    upd_ready = 1'b1;
    tick(); tick();
    check("t5_nothing", 32'(upd_valid), 32'd0);
    upd_ready = 1'b0;
    wr(3'd6, 8'h00);
    check("t5_stage_src", 32'(upd_src), 32'd0);
    check("t5_stage_weight", upd_weight, 32'd0);
    upd_ready = 1'b1;
    tick();

    // writes without both strobes are ignored
    bus(1'b0, 1'b1, 3'd0, 8'd17);
    bus(1'b1, 1'b0, 3'd0, 8'd18);
    upd_ready = 1'b0;
    wr(3'd6, 8'h00);
    check("t6_ignored_src", 32'(upd_src), 32'd0);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    wr(3'd0, 8'd19);
    wr(3'd6, 8'h00);
    check("t6_written_src", 32'(upd_src), 32'd19);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/forex_update_ingress.md
# forex_update_ingress

Host-side ingress stage for the FOREX arbitrage peripheral. Accepts byte-wide Avalon-MM writes from the HPS, stages one exchange-rate edge update (source currency, destination currency, 32-bit log-weight), and on a commit write pushes it into a small FIFO. The FIFO drains over a valid/ready handshake into the edge-update port of the graph container. Sits between the Avalon slave decode in the FOREX top level and the container.

## Interface

- DEPTH, 4, FIFO entries; power of two, ≥2
- NODE_W, 5, currency index width
- WEIGHT_W, 32, edge weight width; fixed at 32, four bytes
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon chip select; a write takes effect only when chipselect && write
- address  in  3  Avalon register address
- upd_valid  out  1  FIFO head holds a valid update
- upd_ready  in  1  container accepts head this cycle
- upd_src  out  NODE_W  head source index
- upd_dst  out  NODE_W  head destination index
- upd_weight  out  32  head weight
- fifo_full  out  1  FIFO holds DEPTH entries
- drop_count  out  8  commits rejected because FIFO full; saturating

## Operation

- Register map, written when chipselect && write:
  - 0: stage_src <= writedata[NODE_W-1:0]
  - 1: stage_dst <= writedata[NODE_W-1:0]
  - 2..5: stage_weight bytes 0..3, little-endian; address 2 = bits 7:0, address 5 = bits 31:24
  - 6: commit; writedata ignored
  - 7: control; writedata[0]=1 flushes. Other bits ignored; writedata[0]=0 is a no-op.
- Staging registers keep their values after commit. A repeated commit re-pushes the same record.
- Commit with FIFO not full: push {stage_src, stage_dst, stage_weight} at the tail.
- Commit with FIFO full: no push; drop_count increments, saturating at 255.
- Full is evaluated on the registered count before any same-cycle pop. A commit while full with a simultaneous pop is still dropped.
- Pop occurs when upd_valid && upd_ready. The head advances and the next entry is presented the following cycle.
- Flush empties the FIFO (count and pointers to 0) and clears drop_count. Staging registers are unaffected.
  - Flush overrides a same-cycle pop.
  - Commit and flush cannot occur in the same cycle, since they are distinct addresses.
- Count width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- upd_src, upd_dst and upd_weight are don't-care when upd_valid=0. They must be stable while upd_valid=1 && upd_ready=0.

## Timing

- Reset (reset=0 at a clock edge):
  - stage_src, stage_dst, stage_weight = 0
  - FIFO empty; upd_valid = 0, fifo_full = 0, drop_count = 0
  - upd_src, upd_dst, upd_weight = 0
  - Applying reset mid-operation discards all queued entries.
- Register writes update staging on the edge of the write cycle. A commit on the very next cycle captures the new value.
- Commit latency: a commit at edge N into an empty FIFO gives upd_valid=1 after edge N (visible in cycle N+1).
- upd_valid is driven from registered count (count != 0). There is no combinational path from write or address to upd_valid.
- upd_ready may be held high continuously. One entry drains per cycle.
- fifo_full = (count == DEPTH), registered-derived. It rises the cycle after the DEPTH-th push.
- Push and pop in the same cycle with 0 < count < DEPTH leaves count unchanged. Order is preserved.

## Test plan

- Reset, then write src=3, dst=7, weight bytes 0x78,0x56,0x34,0x12 at addresses 2..5, then commit, with upd_ready=1 -> one cycle of upd_valid=1 with src=3, dst=7, weight=0x12345678; then upd_valid=0.
- upd_ready=0, commit 5 times with DEPTH=4, changing src 1..5 before each commit -> fifo_full=1 after 4th commit, drop_count=1; raise upd_ready -> src 1,2,3,4 emitted in order, then upd_valid=0.
- FIFO full with upd_ready=1, commit in the same cycle as a pop -> commit dropped (drop_count increments), count becomes DEPTH-1.
- 300 commits while full -> drop_count saturates at 255; write 0x01 to address 7 -> upd_valid=0, drop_count=0, staging retained; next commit emits the previous staged record.
- Two queued entries, assert reset=0 for one cycle mid-drain with upd_ready=0 -> upd_valid=0, all outputs 0, nothing emitted afterwards.
- Write chipselect=0 && write=1 to address 0, or chipselect=1 && write=0, then commit -> emitted src is unchanged from prior staging.
